// File: rtl/li_expander.sv
// ---------------------------------------------------------------------------
// li_expander
// Load-immediate expander for the MIPS-32 instruction path. Takes a 32-bit
// constant plus destination register and emits the shortest equivalent
// sequence: a single addi, or lui followed by an ori that is skipped when
// the low half is zero.
//
// Optional build macro: LI_ZEXT_OPT_EN
//   When defined, values with hi == 0 and lo[15] == 1 become a single
//   "ori rt,$zero,lo" instead of lui + ori.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       constant/register pair valid
//   in_ready       block can accept a pair (high only in IDLE)
//   in_value       constant to load
//   in_rt          destination register; $zero requests are dropped
//   out_valid      out_instr valid
//   out_ready      consumer takes out_instr
//   out_instr      encoded MIPS instruction word
//   out_last       current word ends its sequence
//   words_emitted  running count of handed-off words, wraps
//
// state  | meaning
// IDLE   | waiting for a constant, in_ready high
// WORD_A | first word presented (addi / lui / ori-zext)
// WORD_B | second word (ori) presented after a lui
// ---------------------------------------------------------------------------
module li_expander #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_value,
   input  logic [4:0]       in_rt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_last,
   output logic [CNT_W-1:0] words_emitted
);

   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WORD_A = 2'd1,
      WORD_B = 2'd2
   } state_t;

   state_t           state_q;
   logic             out_valid_q;
   logic [31:0]      instr_q;
   logic             last_q;
   logic [4:0]       rt_q;
   logic [15:0]      lo_q;
   logic [CNT_W-1:0] cnt_q;

   logic [15:0] hi_d;
   logic [15:0] lo_d;
   logic        fits_d;
   logic [31:0] instr_d;
   logic        last_d;

   // First-word classification of the incoming constant.
   always_comb begin
      hi_d    = in_value[31:16];
      lo_d    = in_value[15:0];
      // Representable as a sign-extended 16-bit immediate.
      fits_d  = (&in_value[31:15]) | ~(|in_value[31:15]);
      instr_d = {OP_LUI, 5'd0, in_rt, hi_d};
      last_d  = (lo_d == 16'h0000);
      if (fits_d) begin
         instr_d = {OP_ADDI, 5'd0, in_rt, lo_d};
         last_d  = 1'b1;
      end
`ifdef LI_ZEXT_OPT_EN
      else if (hi_d == 16'h0000) begin
         instr_d = {OP_ORI, 5'd0, in_rt, lo_d};
         last_d  = 1'b1;
      end
`else
      else begin
         instr_d = {OP_LUI, 5'd0, in_rt, hi_d};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         instr_q     <= 32'h0000_0000;
         last_q      <= 1'b0;
         rt_q        <= 5'd0;
         lo_q        <= 16'h0000;
      end else begin
         case (state_q)
            IDLE: begin
               // rt == 0 writes nothing architecturally, so drop it.
               if (in_valid && (in_rt != 5'd0)) begin
                  rt_q        <= in_rt;
                  lo_q        <= in_value[15:0];
                  instr_q     <= instr_d;
                  last_q      <= last_d;
                  out_valid_q <= 1'b1;
                  state_q     <= WORD_A;
               end
            end
            WORD_A: begin
               if (out_ready) begin
                  if (last_q) begin
                     out_valid_q <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     // ori follows immediately, out_valid stays high.
                     instr_q <= {OP_ORI, rt_q, rt_q, lo_q};
                     last_q  <= 1'b1;
                     state_q <= WORD_B;
                  end
               end
            end
            WORD_B: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (out_valid_q && out_ready) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = out_valid_q;
   assign out_instr     = instr_q;
   assign out_last      = last_q;
   assign words_emitted = cnt_q;

endmodule

// File: tb/tb_li_expander.sv
module tb_li_expander;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [4:0]  in_rt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic [15:0] words_emitted;

   li_expander #(.CNT_W(16)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_value      (in_value),
      .in_rt         (in_rt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_last      (out_last),
      .words_emitted (words_emitted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [15:0] exp_cnt = 16'd0;

   typedef struct {
      logic [31:0] value;
      logic [4:0]  rt;
      int          stall;
      int          nexp;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: shortest sequence derived from the numeric value of the constant.
   function automatic void model(input logic [31:0] v, input logic [4:0] rt,
                                 output int n, output logic [31:0] w0, output logic [31:0] w1);
      longint unsigned uv = longint'(v);
      longint          sv = longint'($signed(v));
      longint unsigned lo = uv % 65536;
      longint unsigned hi = uv / 65536;
      longint unsigned r  = longint'(rt);
      n  = 0;
      w0 = 32'h0;
      w1 = 32'h0;
      if (rt == 5'd0) begin
         n = 0;
      end else if (sv >= -32768 && sv <= 32767) begin
         n  = 1;
         w0 = 32'(64'h2000_0000 + r * 65536 + lo);
      end
`ifdef LI_ZEXT_OPT_EN
      else if (hi == 0) begin
         n  = 1;
         w0 = 32'(64'h3400_0000 + r * 65536 + lo);
      end
`endif
      else begin
         w0 = 32'(64'h3C00_0000 + r * 65536 + hi);
         if (lo == 0) n = 1;
         else begin
            n  = 2;
            w1 = 32'(64'h3400_0000 + r * 2097152 + r * 65536 + lo);
         end
      end
   endfunction

   // Entered and left on a falling edge.
   task automatic run_seq(input logic [31:0] value, input logic [4:0] rt, input int stall,
                          input bit rnd_ready, input int nexp,
                          input logic [31:0] e0, input logic [31:0] e1, input string tag);
      int          guard;
      int          got;
      int          cyc;
      int          stall_left;
      bit          have_prev;
      bit          rdy;
      logic [31:0] prev_instr;
      logic        prev_last;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      in_value  = value;
      in_rt     = rt;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_value = $urandom;
      in_rt    = 5'($urandom);
      if (nexp == 0) begin
         repeat (3) begin
            check({tag, " dropped out_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
         end
         check({tag, " dropped in_ready"}, 32'(in_ready), 32'd1);
         check({tag, " dropped count"}, 32'(words_emitted), 32'(exp_cnt));
         return;
      end
      got        = 0;
      cyc        = 0;
      stall_left = stall;
      have_prev  = 1'b0;
      prev_instr = 32'h0;
      prev_last  = 1'b0;
      while (got < nexp && cyc < 100) begin
         check({tag, " out_valid in sequence"}, 32'(out_valid), 32'd1);
         check({tag, " in_ready in sequence"}, 32'(in_ready), 32'd0);
         if (have_prev) begin
            check({tag, " held instr"}, out_instr, prev_instr);
            check({tag, " held last"}, 32'(out_last), 32'(prev_last));
         end
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else if (rnd_ready) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         out_ready = rdy;
         if (rdy) begin
            check({tag, " instr"}, out_instr, (got == 0) ? e0 : e1);
            check({tag, " last"}, 32'(out_last), 32'(got == nexp - 1));
            got++;
            exp_cnt   = exp_cnt + 16'd1;
            have_prev = 1'b0;
         end else begin
            have_prev  = 1'b1;
            prev_instr = out_instr;
            prev_last  = out_last;
         end
         @(negedge clk);
         cyc++;
      end
      if (got < nexp) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s timeout: got %0d words expected %0d", tag, got, nexp);
      end
      out_ready = 1'b0;
      check({tag, " out_valid after"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after"}, 32'(in_ready), 32'd1);
      check({tag, " count"}, 32'(words_emitted), 32'(exp_cnt));
   endtask

   logic [31:0] bounds[10] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_7FFF, 32'hFFFF_8000,
                               32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF,
                               32'h8000_0000, 32'h7FFF_FFFF};

   initial begin
      int          n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] v;
      logic [4:0]  rt;

      vecs[0] = '{32'h0000_0005, 5'd8,  0, 1, 32'h2008_0005, 32'h0};
      vecs[1] = '{32'hFFFF_8000, 5'd9,  0, 1, 32'h2009_8000, 32'h0};
      vecs[2] = '{32'h1234_5678, 5'd10, 3, 2, 32'h3C0A_1234, 32'h354A_5678};
      vecs[3] = '{32'h0001_0000, 5'd11, 0, 1, 32'h3C0B_0001, 32'h0};
      vecs[4] = '{32'hDEAD_BEEF, 5'd0,  0, 0, 32'h0,         32'h0};
`ifdef LI_ZEXT_OPT_EN
      vecs[5] = '{32'h0000_8000, 5'd12, 0, 1, 32'h340C_8000, 32'h0};
`else
      vecs[5] = '{32'h0000_8000, 5'd12, 0, 2, 32'h3C0C_0000, 32'h358C_8000};
`endif
      vecs[6] = '{32'h0000_7FFF, 5'd31, 1, 1, 32'h201F_7FFF, 32'h0};
      vecs[7] = '{32'hFFFF_7FFF, 5'd1,  2, 2, 32'h3C01_FFFF, 32'h3421_7FFF};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_value  = 32'h0;
      in_rt     = 5'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_instr", out_instr, 32'h0);
      check("reset out_last", 32'(out_last), 32'd0);
      check("reset words_emitted", 32'(words_emitted), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_seq(vecs[i].value, vecs[i].rt, vecs[i].stall, 1'b0, vecs[i].nexp,
                 vecs[i].w0, vecs[i].w1, $sformatf("vec%0d", i));
      end

      // Reset right after the lui handshake: the ori must never appear.
      in_value  = 32'h1234_5678;
      in_rt     = 5'd10;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      check("rst-mid lui", out_instr, 32'h3C0A_1234);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      exp_cnt = 16'd0;
      check("rst-mid out_valid", 32'(out_valid), 32'd0);
      check("rst-mid count", 32'(words_emitted), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst-mid no ori", 32'(out_valid), 32'd0);
         check("rst-mid in_ready", 32'(in_ready), 32'd1);
      end
      check("rst-mid count after", 32'(words_emitted), 32'd0);
      out_ready = 1'b0;

      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($signed(16'($urandom)));
            2: v = {16'h0000, 16'($urandom)};
            3: v = {16'($urandom), 16'h0000};
            default: v = bounds[$urandom_range(0, 9)];
         endcase
         rt = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         model(v, rt, n, w0, w1);
         run_seq(v, rt, $urandom_range(0, 2), 1'b1, n, w0, w1, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
